// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute stage sitting in front of the 64-bit ALU.
// It accepts one decoded op per handshake and selects the operands, forwarding
// the result currently held in RESULT when a source register matches it.
// It pulses the ALU for one cycle, then presents the result with its
// destination tag to writeback. An illegal opcode skips the ALU entirely and
// is reported with wb_err set.
module alu_issue_stage #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int REG_IDX_W      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_alu_ctl,
  input  logic [REG_IDX_W-1:0]      in_rs1,
  input  logic [REG_IDX_W-1:0]      in_rs2,
  input  logic [REG_IDX_W-1:0]      in_rd,
  input  logic [BUS_DATA_WIDTH-1:0] in_rs1_data,
  input  logic [BUS_DATA_WIDTH-1:0] in_rs2_data,
  input  logic [BUS_DATA_WIDTH-1:0] in_imm,
  input  logic                      in_use_imm,
  output logic [5:0]                alu_control,
  output logic [BUS_DATA_WIDTH-1:0] dataA,
  output logic [BUS_DATA_WIDTH-1:0] dataB,
  output logic                      fetch_en,
  input  logic [BUS_DATA_WIDTH-1:0] alu_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_IDX_W-1:0]      wb_rd,
  output logic [BUS_DATA_WIDTH-1:0] wb_data,
  output logic                      wb_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic                      accept_s;
  logic                      illegal_s;
  logic                      fwd_ok_s;
  logic [BUS_DATA_WIDTH-1:0] src_a_s;
  logic [BUS_DATA_WIDTH-1:0] rs2_val_s;
  logic [BUS_DATA_WIDTH-1:0] src_b_s;

  // Opcodes with no ALU operation behind them.
  function automatic logic is_illegal(input logic [5:0] ctl);
    is_illegal = (ctl == 6'b000000) || (ctl == 6'b001010) ||
                 (ctl == 6'b001011) || (ctl >= 6'b101100);
  endfunction

  // Source value: x0 reads as zero, a match on the held result forwards the
  // live ALU output, anything else takes the register file read.
  function automatic logic [BUS_DATA_WIDTH-1:0] src_value(
    input logic [REG_IDX_W-1:0]      idx,
    input logic [BUS_DATA_WIDTH-1:0] rf_data,
    input logic                      fwd_ok,
    input logic [REG_IDX_W-1:0]      held_rd,
    input logic [BUS_DATA_WIDTH-1:0] fwd_data
  );
    if (idx == {REG_IDX_W{1'b0}}) begin
      src_value = {BUS_DATA_WIDTH{1'b0}};
    end else if (fwd_ok && (idx == held_rd)) begin
      src_value = fwd_data;
    end else begin
      src_value = rf_data;
    end
  endfunction

  assign in_ready  = (state_r == IDLE) || ((state_r == RESULT) && wb_ready);
  assign accept_s  = in_valid && in_ready;
  assign illegal_s = is_illegal(in_alu_ctl);
  // Only a legal result that is actually being held may be forwarded.
  assign fwd_ok_s  = (state_r == RESULT) && !wb_err;
  assign src_a_s   = src_value(in_rs1, in_rs1_data, fwd_ok_s, wb_rd, alu_result);
  assign rs2_val_s = src_value(in_rs2, in_rs2_data, fwd_ok_s, wb_rd, alu_result);
  assign src_b_s   = in_use_imm ? in_imm : rs2_val_s;
  // The ALU keeps its output steady while fetch_en is low, so the result
  // path is passed straight through; error results read as zero.
  assign wb_data   = (wb_valid && !wb_err) ? alu_result : {BUS_DATA_WIDTH{1'b0}};

  // Next-state selection for the issue/result sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = illegal_s ? RESULT : ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = RESULT;
      end
      RESULT: begin
        if (!wb_ready) begin
          state_next_s = RESULT;
        end else if (in_valid) begin
          state_next_s = illegal_s ? RESULT : ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, registered ALU drive, and captured destination tag and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      fetch_en    <= 1'b0;
      wb_valid    <= 1'b0;
      alu_control <= 6'b000000;
      dataA       <= {BUS_DATA_WIDTH{1'b0}};
      dataB       <= {BUS_DATA_WIDTH{1'b0}};
      wb_rd       <= {REG_IDX_W{1'b0}};
      wb_err      <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      fetch_en <= (state_next_s == ISSUE);
      wb_valid <= (state_next_s == RESULT);
      if (accept_s) begin
        wb_rd  <= in_rd;
        wb_err <= illegal_s;
        // Illegal ops never reach the ALU, so its inputs keep their last values.
        if (!illegal_s) begin
          alu_control <= in_alu_ctl;
          dataA       <= src_a_s;
          dataB       <= src_b_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU and a scoreboard
// of expected ALU operands and expected writeback results.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_alu_ctl;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [63:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [5:0]  alu_control;
  logic [63:0] dataA, dataB;
  logic        fetch_en;
  logic [63:0] alu_result = 64'd0;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [4:0] rd; logic [63:0] data; logic err; } res_t;
  typedef struct { logic [5:0] ctl; logic [63:0] a; logic [63:0] b; } opx_t;
  res_t  res_q[$];
  opx_t  op_q[$];
  logic [63:0] arch [32];

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctl(in_alu_ctl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .alu_control(alu_control), .dataA(dataA),
    .dataB(dataB), .fetch_en(fetch_en), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU used by the bench.
  function automatic logic [63:0] alu_f(input logic [5:0] ctl, input logic [63:0] a, input logic [63:0] b);
    case (ctl)
      6'd1:    alu_f = a + b;
      6'd2:    alu_f = a - b;
      6'd3:    alu_f = a & b;
      default: alu_f = a ^ b;
    endcase
  endfunction

  // ALU captures its inputs on the edge that ends the issue cycle.
  always @(posedge clk) begin
    if (fetch_en) alu_result <= alu_f(alu_control, dataA, dataB);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic note_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  // Present one op, wait (bounded) for acceptance and record its expectations.
  task automatic send_op(input logic [5:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] imm, input logic use_imm);
    logic [63:0] ea, eb, r;
    logic ill;
    int budget;
    @(negedge clk);
    in_alu_ctl = ctl; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      note_fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    ea  = (rs1 == 5'd0) ? 64'd0 : arch[rs1];
    eb  = use_imm ? imm : ((rs2 == 5'd0) ? 64'd0 : arch[rs2]);
    ill = (ctl == 6'd0) || (ctl == 6'd10) || (ctl == 6'd11) || (ctl > 6'd43);
    if (ill) begin
      res_q.push_back('{rd, 64'd0, 1'b1});
    end else begin
      r = alu_f(ctl, ea, eb);
      op_q.push_back('{ctl, ea, eb});
      res_q.push_back('{rd, r, 1'b0});
      if (rd != 5'd0) arch[rd] = r;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Compare ALU drive on every fetch pulse and every consumed writeback result.
  always @(negedge clk) begin
    opx_t eo;
    res_t er;
    if (!reset && fetch_en) begin
      if (op_q.size() == 0) note_fail("unexpected_fetch_en");
      else begin
        eo = op_q.pop_front();
        chk("alu_control", {58'd0, alu_control}, {58'd0, eo.ctl});
        chk("dataA", dataA, eo.a);
        chk("dataB", dataB, eo.b);
      end
    end
    if (!reset && wb_valid && wb_ready) begin
      if (res_q.size() == 0) note_fail("unexpected_wb_valid");
      else begin
        er = res_q.pop_front();
        chk("wb_rd", {59'd0, wb_rd}, {59'd0, er.rd});
        chk("wb_data", wb_data, er.data);
        chk("wb_err", {63'd0, wb_err}, {63'd0, er.err});
      end
    end
  end

  initial begin
    logic [5:0]  codes [9];
    logic [63:0] saved;
    int w;
    codes = '{6'd9, 6'd0, 6'd12, 6'd11, 6'd43, 6'd44, 6'd2, 6'd63, 6'd3};
    for (int i = 0; i < 32; i++) arch[i] = 64'd0;
    reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
    in_alu_ctl = 6'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rs1_data = 64'd0; in_rs2_data = 64'd0; in_imm = 64'd0; in_use_imm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_fetch_en", {63'd0, fetch_en}, 64'd0);
    chk("rst_alu_control", {58'd0, alu_control}, 64'd0);
    chk("rst_dataA", dataA, 64'd0);
    chk("rst_dataB", dataB, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_err", {63'd0, wb_err}, 64'd0);
    chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // addi x3 = x1 + 7
    arch[1] = 64'd5;
    send_op(6'd1, 5'd1, 5'd0, 5'd3, 64'd5, 64'd0, 64'd7, 1'b1);
    chk("t1_fetch_en", {63'd0, fetch_en}, 64'd1);
    chk("t1_in_ready_issue", {63'd0, in_ready}, 64'd0);
    chk("t1_wb_valid_issue", {63'd0, wb_valid}, 64'd0);
    @(posedge clk); #1;
    chk("t1_fetch_en_drop", {63'd0, fetch_en}, 64'd0);
    chk("t1_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("t1_wb_data", wb_data, 64'd12);

    // add x4 = x3 + x3 while x3 sits in RESULT, stale register data
    send_op(6'd1, 5'd3, 5'd3, 5'd4, 64'd0, 64'd0, 64'd0, 1'b0);
    chk("t2_back_to_back", {63'd0, fetch_en}, 64'd1);
    @(posedge clk); #1;
    chk("t2_wb_data", wb_data, 64'd24);

    // writeback stall for 5 cycles
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_wb_valid", {63'd0, wb_valid}, 64'd1);
      chk("t3_wb_data", wb_data, 64'd24);
      chk("t3_wb_rd", {59'd0, wb_rd}, 64'd4);
      chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t3_fetch_en", {63'd0, fetch_en}, 64'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_valid", {63'd0, wb_valid}, 64'd0);
    chk("t3_release_ready", {63'd0, in_ready}, 64'd1);

    // illegal op to x7, then x7 read must use register file data
    arch[7] = 64'h55;
    send_op(6'd10, 5'd0, 5'd0, 5'd7, 64'd0, 64'd0, 64'd0, 1'b0);
    chk("t4_no_fetch", {63'd0, fetch_en}, 64'd0);
    chk("t4_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("t4_wb_err", {63'd0, wb_err}, 64'd1);
    chk("t4_wb_data", wb_data, 64'd0);
    send_op(6'd1, 5'd7, 5'd0, 5'd8, 64'h55, 64'd0, 64'd1, 1'b1);
    @(posedge clk); #1;
    chk("t4_next_data", wb_data, 64'h56);

    // opcode boundaries around the illegal ranges, back to back
    for (int i = 0; i < 9; i++)
      send_op(codes[i], 5'd1, 5'd3, 5'(10 + i), arch[1], arch[3], 64'd0, 1'b0);

    // x0 destination still presented; x0 source reads zero even when wb_rd==0
    send_op(6'd1, 5'd1, 5'd0, 5'd0, arch[1], 64'd0, 64'd3, 1'b1);
    send_op(6'd1, 5'd0, 5'd0, 5'd9, 64'hDEAD, 64'd0, 64'd4, 1'b1);
    chk("t5_dataA_x0", dataA, 64'd0);
    w = 0;
    while (res_q.size() != 0 && w < 30) begin @(posedge clk); w++; end
    chk("t5_drain", 64'(res_q.size()), 64'd0);

    // reset during ISSUE drops the op
    saved = arch[20];
    send_op(6'd2, 5'd1, 5'd3, 5'd20, arch[1], arch[3], 64'd0, 1'b0);
    chk("t6_in_issue", {63'd0, fetch_en}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_fetch_en_async", {63'd0, fetch_en}, 64'd0);
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t6_wb_valid", {63'd0, wb_valid}, 64'd0);
    res_q.delete();
    op_q.delete();
    arch[20] = saved;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_no_result", {63'd0, wb_valid}, 64'd0);
    end
    send_op(6'd3, 5'd3, 5'd4, 5'd21, arch[3], arch[4], 64'd0, 1'b0);
    w = 0;
    while (res_q.size() != 0 && w < 30) begin @(posedge clk); w++; end
    chk("final_drain", 64'(res_q.size()), 64'd0);
    chk("final_op_drain", 64'(op_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
